// File: rtl/mmio_timer.sv
// Memory-mapped timer on the MEM-stage data bus: reloadable up-counter with a
// sticky interrupt flag, plus a free-running cycle counter.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        irq
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] systick;
  logic        en;
  logic        ie;
  logic        iflag;

  logic sel_th, sel_tl, sel_tcon, sel_systick;
  logic wr_th, wr_tl, wr_tcon;
  logic run;
  logic overflow;

  assign sel_th      = (Address == BASE_ADDR);
  assign sel_tl      = (Address == BASE_ADDR + 32'h4);
  assign sel_tcon    = (Address == BASE_ADDR + 32'h8);
  assign sel_systick = (Address == BASE_ADDR + 32'h14);

  assign wr_th   = MemWrite && sel_th;
  assign wr_tl   = MemWrite && sel_tl;
  assign wr_tcon = MemWrite && sel_tcon;

  // Clearing EN stops the counter on the same edge; setting EN starts it on the next one.
  assign run      = en && !(wr_tcon && !Write_data[0]);
  assign overflow = run && (tl == 32'hFFFFFFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      systick <= '0;
      en      <= 1'b0;
      ie      <= 1'b0;
      iflag   <= 1'b0;
    end else begin
      systick <= systick + 32'd1;

      if (wr_th) th <= Write_data;

      if (wr_tl)         tl <= Write_data;
      else if (overflow) tl <= th;
      else if (run)      tl <= tl + 32'd1;

      if (wr_tcon) begin
        en <= Write_data[0];
        ie <= Write_data[1];
      end

      // Hardware set beats a simultaneous software clear; software can never set IF.
      if (overflow && ie) iflag <= 1'b1;
      else if (wr_tcon)   iflag <= Write_data[2] & iflag;
    end
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (sel_th)           Read_data = th;
      else if (sel_tl)      Read_data = tl;
      else if (sel_tcon)    Read_data = {29'd0, iflag, ie, en};
      else if (sel_systick) Read_data = systick;
    end
  end

  assign irq = iflag & ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, reload/interrupt, IF clear races,
// write priority, address decode and IE=0 overflow.
module tb_mmio_timer;

  localparam logic [31:0] A_TH   = 32'h40000000;
  localparam logic [31:0] A_TL   = 32'h40000004;
  localparam logic [31:0] A_TCON = 32'h40000008;
  localparam logic [31:0] A_DIG  = 32'h40000010;
  localparam logic [31:0] A_SYS  = 32'h40000014;

  logic        reset;
  logic        clk;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        irq;

  int unsigned tests;
  int unsigned fails;
  logic [31:0] s0;
  logic [31:0] exp_tl [4];

  mmio_timer #(.BASE_ADDR(32'h40000000)) dut (
    .reset     (reset),
    .clk       (clk),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .Write_data(Write_data),
    .Read_data (Read_data),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
    MemRead = 1'b1;
    Address = addr;
    #1;
    check(tag, Read_data, expv);
    MemRead = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    MemRead = 1'b1;
    Address = addr;
    #1;
    data = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite   = 1'b1;
    Address    = addr;
    Write_data = data;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Address = '0;
    Write_data = '0;

    // Power-on reset state
    @(posedge clk); #1;
    chk_rd("rst_systick", A_SYS, 32'h0);
    chk_rd("rst_tcon", A_TCON, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    chk_rd("rel_systick0", A_SYS, 32'h0);
    @(posedge clk); #1;
    chk_rd("rel_systick1", A_SYS, 32'h1);

    // 1. Reset mid-count
    do_wr(A_TH, 32'h7);
    do_wr(A_TL, 32'h5);
    do_wr(A_TCON, 32'h1);
    chk_rd("t1_tl_en_edge", A_TL, 32'h5);
    @(posedge clk); #1;
    chk_rd("t1_tl_inc", A_TL, 32'h6);
    reset = 1'b1;
    chk_rd("t1_th_clr", A_TH, 32'h0);
    chk_rd("t1_tl_clr", A_TL, 32'h0);
    chk_rd("t1_tcon_clr", A_TCON, 32'h0);
    chk_rd("t1_sys_clr", A_SYS, 32'h0);
    check("t1_irq_clr", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    chk_rd("t1_sys_rel0", A_SYS, 32'h0);
    @(posedge clk); #1;
    chk_rd("t1_sys_rel1", A_SYS, 32'h1);
    chk_rd("t1_tl_held", A_TL, 32'h0);

    // 2. Reload and interrupt
    do_wr(A_TH, 32'hFFFFFFFC);
    do_wr(A_TL, 32'hFFFFFFFC);
    do_wr(A_TCON, 32'h3);
    chk_rd("t2_tl_start", A_TL, 32'hFFFFFFFC);
    check("t2_irq_start", {31'd0, irq}, 32'h0);
    exp_tl[0] = 32'hFFFFFFFD;
    exp_tl[1] = 32'hFFFFFFFE;
    exp_tl[2] = 32'hFFFFFFFF;
    exp_tl[3] = 32'hFFFFFFFC;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_rd($sformatf("t2_tl_%0d", i), A_TL, exp_tl[i]);
      check($sformatf("t2_irq_%0d", i), {31'd0, irq}, (i == 3) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1;
    chk_rd("t2_tl_after", A_TL, 32'hFFFFFFFD);
    chk_rd("t2_tcon_if", A_TCON, 32'h7);
    check("t2_irq_sticky", {31'd0, irq}, 32'h1);

    // 3. Interrupt clear, then clear racing an overflow
    do_wr(A_TCON, 32'h3);
    check("t3_irq_cleared", {31'd0, irq}, 32'h0);
    chk_rd("t3_tcon_cleared", A_TCON, 32'h3);
    chk_rd("t3_tl", A_TL, 32'hFFFFFFFE);
    @(posedge clk); #1;
    chk_rd("t3_tl_ff", A_TL, 32'hFFFFFFFF);
    do_wr(A_TCON, 32'h3);
    chk_rd("t3_race_tcon", A_TCON, 32'h7);
    check("t3_race_irq", {31'd0, irq}, 32'h1);
    chk_rd("t3_race_tl", A_TL, 32'hFFFFFFFC);
    do_wr(A_TCON, 32'h3);
    do_wr(A_TCON, 32'h7);
    chk_rd("t3_no_sw_set", A_TCON, 32'h3);
    chk_rd("t3_tl_fe", A_TL, 32'hFFFFFFFE);
    do_wr(A_TCON, 32'h0);
    chk_rd("t3_en_clr_same_edge", A_TL, 32'hFFFFFFFE);
    @(posedge clk); #1;
    chk_rd("t3_tl_stopped", A_TL, 32'hFFFFFFFE);

    // 4. CPU write to TL beats the increment
    do_wr(A_TL, 32'h10);
    do_wr(A_TCON, 32'h1);
    chk_rd("t4_tl_10", A_TL, 32'h10);
    do_wr(A_TL, 32'h100);
    chk_rd("t4_tl_100", A_TL, 32'h100);
    @(posedge clk); #1;
    chk_rd("t4_tl_101", A_TL, 32'h101);

    // 5. Decode isolation and read-during-write
    do_wr(A_TCON, 32'h0);
    do_wr(A_DIG, 32'h123);
    rd(A_SYS, s0);
    do_wr(A_SYS, 32'h55);
    chk_rd("t5_sys_ro", A_SYS, s0 + 32'd1);
    chk_rd("t5_th", A_TH, 32'hFFFFFFFC);
    chk_rd("t5_tl", A_TL, 32'h101);
    chk_rd("t5_tcon", A_TCON, 32'h0);
    chk_rd("t5_rd_dig", A_DIG, 32'h0);
    chk_rd("t5_rd_18", 32'h40000018, 32'h0);
    chk_rd("t5_rd_low", 32'h00000004, 32'h0);
    Address = A_TL;
    MemRead = 1'b0;
    #1;
    check("t5_noread", Read_data, 32'h0);
    MemRead = 1'b1;
    MemWrite = 1'b1;
    Address = A_TH;
    Write_data = 32'h1234;
    #1;
    check("t5_rdw_old", Read_data, 32'hFFFFFFFC);
    @(posedge clk); #1;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    chk_rd("t5_rdw_new", A_TH, 32'h1234);

    // 6. Overflow with IE = 0
    do_wr(A_TH, 32'hFFFFFFFE);
    do_wr(A_TL, 32'hFFFFFFFF);
    do_wr(A_TCON, 32'h1);
    chk_rd("t6_tl_start", A_TL, 32'hFFFFFFFF);
    rd(A_SYS, s0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk_rd($sformatf("t6_tl_%0d", i), A_TL, (i % 2 == 1) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
      chk_rd($sformatf("t6_tcon_%0d", i), A_TCON, 32'h1);
      check($sformatf("t6_irq_%0d", i), {31'd0, irq}, 32'h0);
      chk_rd($sformatf("t6_sys_%0d", i), A_SYS, s0 + 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
